bidir_shift_reg: RTL and testbench

Parametrised universal shift register. It loads in parallel, and it can shift or rotate right or left and shift arithmetic-right, either one step per enabled cycle or as a counted burst of N steps with busy/done status. It is the successor to the single-mode right-shift register, with the same load/enable semantics but more modes, a serial-out bit and burst sequencing. It sits in the serialiser/datapath alignment slot of the register library.

---
 rtl/bidir_shift_reg.sv | 112 +++++++++++
 tb/tb_bidir_shift_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bidir_shift_reg.sv
// rtl/bidir_shift_reg.sv - universal shift/rotate register with single-step and counted-burst sequencing
module bidir_shift_reg #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          sync_rst_n,
    input  logic          load,
    input  logic [DW-1:0] data,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic          start,
    input  logic [CW-1:0] cnt,
    input  logic          data_h,
    input  logic          data_l,
    output logic [DW-1:0] q,
    output logic          so,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] q_n;
    logic          so_n;
    logic          done_n;
    logic [CW-1:0] rem, rem_n;
    logic [2:0]    mode_r, mode_r_n;

    logic [2:0]    step_mode;
    logic [DW-1:0] step_q;
    logic          step_so;

    // A burst uses the mode captured at its start; otherwise the live mode applies.
    assign step_mode = (state == BURST) ? mode_r : mode;
    assign busy      = (state == BURST);

    always_comb begin
        step_q  = q;
        step_so = so;
        case (step_mode)
            3'd0: begin step_q = {data_h, q[DW-1:1]};    step_so = q[0];    end
            3'd1: begin step_q = {q[DW-2:0], data_l};    step_so = q[DW-1]; end
            3'd2: begin step_q = {q[0], q[DW-1:1]};      step_so = q[0];    end
            3'd3: begin step_q = {q[DW-2:0], q[DW-1]};   step_so = q[DW-1]; end
            3'd4: begin step_q = {q[DW-1], q[DW-1:1]};   step_so = q[0];    end
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        q_n      = q;
        so_n     = so;
        done_n   = 1'b0;
        rem_n    = rem;
        mode_r_n = mode_r;
        if (load) begin
            q_n     = data;
            state_n = IDLE;
            rem_n   = '0;
        end else if (state == IDLE && start) begin
            if (cnt == '0) begin
                done_n = 1'b1;
            end else begin
                q_n  = step_q;
                so_n = step_so;
                if (cnt == CW'(1)) begin
                    done_n = 1'b1;
                end else begin
                    mode_r_n = mode;
                    rem_n    = cnt - CW'(1);
                    state_n  = BURST;
                end
            end
        end else if (state == BURST) begin
            q_n   = step_q;
            so_n  = step_so;
            rem_n = rem - CW'(1);
            if (rem == CW'(1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else if (en) begin
            q_n  = step_q;
            so_n = step_so;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state  <= IDLE;
            q      <= '0;
            so     <= 1'b0;
            done   <= 1'b0;
            rem    <= '0;
            mode_r <= 3'd0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            so     <= so_n;
            done   <= done_n;
            rem    <= rem_n;
            mode_r <= mode_r_n;
        end
    end

endmodule

// File: tb/tb_bidir_shift_reg.sv
// tb/tb_bidir_shift_reg.sv - scoreboard bench for bidir_shift_reg against a queue-based reference model
module tb_bidir_shift_reg;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          sync_rst_n;
    logic          load;
    logic [DW-1:0] data;
    logic          en;
    logic [2:0]    mode;
    logic          start;
    logic [CW-1:0] cnt;
    logic          data_h;
    logic          data_l;
    logic [DW-1:0] q;
    logic          so;
    logic          busy;
    logic          done;

    bidir_shift_reg #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .sync_rst_n(sync_rst_n), .load(load), .data(data), .en(en),
        .mode(mode), .start(start), .cnt(cnt), .data_h(data_h), .data_l(data_l),
        .q(q), .so(so), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] q;
        logic          so;
        logic          busy;
        logic          done;
    } snap_t;

    snap_t      exp_q[$];
    int         errors = 0;
    int         checks = 0;

    // Reference state: pending burst steps are simply a queue of the modes still to apply.
    logic [DW-1:0] m_q;
    logic          m_so;
    logic          m_done;
    logic [2:0]    pend[$];

    task automatic apply(input logic [2:0] m);
        logic [DW-1:0] v;
        v = m_q;
        case (m)
            3'd0: begin m_so = v[0];    m_q = (v >> 1) | (DW'(data_h) << (DW-1)); end
            3'd1: begin m_so = v[DW-1]; m_q = (v << 1) | DW'(data_l); end
            3'd2: begin m_so = v[0];    m_q = (v >> 1) | (v << (DW-1)); end
            3'd3: begin m_so = v[DW-1]; m_q = (v << 1) | (v >> (DW-1)); end
            3'd4: begin m_so = v[0];    m_q = DW'($signed(v) >>> 1); end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        if (!sync_rst_n) begin
            m_q = '0; m_so = 1'b0; m_done = 1'b0; pend.delete();
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_q = data;
                pend.delete();
            end else if (pend.size() == 0 && start) begin
                if (cnt == 0) begin
                    m_done = 1'b1;
                end else begin
                    apply(mode);
                    for (int i = 1; i < int'(cnt); i++) pend.push_back(mode);
                    if (cnt == 1) m_done = 1'b1;
                end
            end else if (pend.size() > 0) begin
                apply(pend.pop_front());
                if (pend.size() == 0) m_done = 1'b1;
            end else if (en) begin
                apply(mode);
            end
        end
    endtask

    task automatic tick();
        snap_t s;
        model_edge();
        s.q = m_q; s.so = m_so; s.busy = (pend.size() > 0); s.done = m_done;
        exp_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        sync_rst_n = 1'b1; load = 1'b0; en = 1'b0; start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            checks++;
            if (q !== e.q || so !== e.so || busy !== e.busy || done !== e.done) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got q=%h so=%b busy=%b done=%b expected q=%h so=%b busy=%b done=%b",
                         $time, q, so, busy, done, e.q, e.so, e.busy, e.done);
            end
        end
    end

    initial begin
        m_q = '0; m_so = 1'b0; m_done = 1'b0;
        sync_rst_n = 1'b0; load = 1'b1; data = 8'hA5; en = 1'b1; mode = 3'd0;
        start = 1'b0; cnt = '0; data_h = 1'b0; data_l = 1'b0;
        #2;
        tick(); tick();
        chk("reset_q", int'(q), 0);
        chk("reset_flags", int'({so, busy, done}), 0);

        // SRL steps
        idle_inputs(); load = 1'b1; data = 8'hB4; tick();
        load = 1'b0; mode = 3'd0; data_h = 1'b1; en = 1'b1;
        tick(); chk("srl1", int'({q, so}), int'({8'hDA, 1'b0}));
        tick(); chk("srl2", int'({q, so}), int'({8'hED, 1'b0}));
        tick(); chk("srl3", int'({q, so}), int'({8'hF6, 1'b1}));

        // ROL then SLL
        en = 1'b0; load = 1'b1; data = 8'h81; tick();
        load = 1'b0; mode = 3'd3; en = 1'b1;
        tick(); chk("rol1", int'({q, so}), int'({8'h03, 1'b1}));
        tick(); chk("rol2", int'({q, so}), int'({8'h06, 1'b0}));
        mode = 3'd1; data_l = 1'b1;
        tick(); chk("sll1", int'({q, so}), int'({8'h0D, 1'b0}));

        // SRA burst, with mode/en disturbance while busy
        en = 1'b0; load = 1'b1; data = 8'h90; tick();
        load = 1'b0; mode = 3'd4; start = 1'b1; cnt = 4'd3;
        tick(); chk("sra_b1", int'({q, busy, done}), int'({8'hC8, 1'b1, 1'b0}));
        start = 1'b0; mode = 3'd0; en = 1'b1;
        tick(); chk("sra_b2", int'({q, busy, done}), int'({8'hE4, 1'b1, 1'b0}));
        tick(); chk("sra_b3", int'({q, busy, done}), int'({8'hF2, 1'b0, 1'b1}));
        en = 1'b0;
        tick(); chk("sra_after", int'({q, busy, done}), int'({8'hF2, 1'b0, 1'b0}));

        // zero-length burst
        start = 1'b1; cnt = 4'd0;
        tick(); chk("zero_burst", int'({q, busy, done}), int'({8'hF2, 1'b0, 1'b1}));
        start = 1'b0;
        tick(); chk("zero_burst_done_clr", int'(done), 0);

        // abort by load on the second busy cycle
        mode = 3'd2; start = 1'b1; cnt = 4'd5;
        tick(); chk("ror_b1", int'({q, busy}), int'({8'h79, 1'b1}));
        start = 1'b0;
        tick();
        load = 1'b1; data = 8'h3C;
        tick(); chk("abort", int'({q, busy, done}), int'({8'h3C, 1'b0, 1'b0}));
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("abort_no_done", int'({busy, done}), 0);
        end

        // reset in the middle of a burst
        mode = 3'd1; start = 1'b1; cnt = 4'd7;
        tick(); start = 1'b0;
        tick(); tick();
        sync_rst_n = 1'b0;
        tick(); chk("midrst", int'({q, so, busy, done}), 0);
        sync_rst_n = 1'b1;
        tick(); chk("midrst_no_done", int'(done), 0);
        load = 1'b1; data = 8'h0F; tick(); load = 1'b0;
        mode = 3'd3; start = 1'b1; cnt = 4'd2;
        tick(); chk("post_b1", int'({q, busy}), int'({8'h1E, 1'b1}));
        start = 1'b0;
        tick(); chk("post_b2", int'({q, busy, done}), int'({8'h3C, 1'b0, 1'b1}));

        // randomized traffic, checked only through the scoreboard
        for (int i = 0; i < 600; i++) begin
            sync_rst_n = ($urandom_range(0, 99) >= 2);
            load       = ($urandom_range(0, 99) < 5);
            start      = ($urandom_range(0, 99) < 12);
            en         = $urandom_range(0, 1);
            mode       = 3'($urandom_range(0, 7));
            cnt        = CW'($urandom_range(0, 15));
            data       = DW'($urandom);
            data_h     = $urandom_range(0, 1);
            data_l     = $urandom_range(0, 1);
            tick();
        end

        idle_inputs();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
